// File: rtl/prim_cmd_issuer.sv
// prim_cmd_issuer
//   Queues line descriptors from a host and serialises each one into a short
//   burst of 16-bit renderer command words {opcode[3:0], payload[11:0]}:
//     0x0|x0, 0x1|y0, 0x2|x1, 0x3|y1, 0x4|{4'h0,color}, 0xF|000 (start).
//   The colour word is dropped when the renderer already holds that colour.
//   After the start word the block waits for the renderer's done pulse
//   before it pops the next descriptor.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   desc_valid_i   host offers a descriptor
//   desc_ready_o   FIFO has room (depends on the count only)
//   desc_*_i       descriptor fields: signed 12-bit endpoints, 8-bit colour
//   flush_i        drop all queued work and abandon the current line
//   rndr_done_i    renderer line-complete pulse (used only while waiting)
//   cmd_o          command word; holds its last value while not valid
//   cmd_valid_o    one command word per high cycle
//   busy_o         not idle, or descriptors still queued
//   fifo_count_o   number of queued descriptors
module prim_cmd_issuer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n_i,
  input  logic                          desc_valid_i,
  output logic                          desc_ready_o,
  input  logic [11:0]                   desc_x0_i,
  input  logic [11:0]                   desc_y0_i,
  input  logic [11:0]                   desc_x1_i,
  input  logic [11:0]                   desc_y1_i,
  input  logic [7:0]                    desc_color_i,
  input  logic                          flush_i,
  input  logic                          rndr_done_i,
  output logic [15:0]                   cmd_o,
  output logic                          cmd_valid_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic signed [11:0] x0;
    logic signed [11:0] y0;
    logic signed [11:0] x1;
    logic signed [11:0] y1;
    logic [7:0]         color;
  } desc_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state_q;
  desc_t          mem_q [FIFO_DEPTH];
  desc_t          desc_q;
  desc_t          desc_in;
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [2:0]     idx_q;
  logic [7:0]     cache_q;
  logic           cache_vld_q;
  logic [15:0]    cmd_q;
  logic           cmd_vld_q;
  logic           push;
  logic           pop;

  assign desc_in = '{x0: desc_x0_i, y0: desc_y0_i, x1: desc_x1_i,
                     y1: desc_y1_i, color: desc_color_i};

  assign desc_ready_o = (count_q < CW'(FIFO_DEPTH));
  // Flush wins over everything, so a push or pop in the flush cycle is void.
  assign push = desc_valid_i && desc_ready_o && !flush_i;
  assign pop  = (state_q == IDLE) && (count_q != '0) && !flush_i;

  // NOTE: descriptor storage has no reset; the count and pointers alone
  // decide which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= desc_in;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      desc_q      <= '0;
      idx_q       <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      cmd_q       <= '0;
      cmd_vld_q   <= 1'b0;
    end else begin
      cmd_vld_q <= 1'b0;
      if (flush_i) begin
        state_q     <= IDLE;
        cache_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (pop) begin
              desc_q  <= mem_q[rd_ptr_q];
              idx_q   <= '0;
              state_q <= SEND;
            end
          end
          SEND: begin
            cmd_vld_q <= 1'b1;
            unique case (idx_q)
              3'd0: begin cmd_q <= {4'h0, desc_q.x0}; idx_q <= 3'd1; end
              3'd1: begin cmd_q <= {4'h1, desc_q.y0}; idx_q <= 3'd2; end
              3'd2: begin cmd_q <= {4'h2, desc_q.x1}; idx_q <= 3'd3; end
              3'd3: begin cmd_q <= {4'h3, desc_q.y1}; idx_q <= 3'd4; end
              3'd4: begin
                // Renderer already holds this colour: go straight to start.
                if (cache_vld_q && (cache_q == desc_q.color)) begin
                  cmd_q   <= 16'hF000;
                  state_q <= WAIT;
                end else begin
                  cmd_q       <= {4'h4, 4'h0, desc_q.color};
                  cache_q     <= desc_q.color;
                  cache_vld_q <= 1'b1;
                  idx_q       <= 3'd5;
                end
              end
              default: begin
                cmd_q   <= 16'hF000;
                state_q <= WAIT;
              end
            endcase
          end
          WAIT: begin
            if (rndr_done_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cmd_o        = cmd_q;
  assign cmd_valid_o  = cmd_vld_q;
  assign busy_o       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_prim_cmd_issuer.sv
// Directed bench for prim_cmd_issuer: single line timing, colour reuse,
// full FIFO with wrap, flush mid-burst, async reset, done during a burst.
module tb_prim_cmd_issuer;

  logic        clk;
  logic        reset_n_i;
  logic        desc_valid_i;
  logic        desc_ready_o;
  logic [11:0] desc_x0_i, desc_y0_i, desc_x1_i, desc_y1_i;
  logic [7:0]  desc_color_i;
  logic        flush_i;
  logic        rndr_done_i;
  logic [15:0] cmd_o;
  logic        cmd_valid_o;
  logic        busy_o;
  logic [2:0]  fifo_count_o;

  prim_cmd_issuer #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .desc_valid_i (desc_valid_i),
    .desc_ready_o (desc_ready_o),
    .desc_x0_i    (desc_x0_i),
    .desc_y0_i    (desc_y0_i),
    .desc_x1_i    (desc_x1_i),
    .desc_y1_i    (desc_y1_i),
    .desc_color_i (desc_color_i),
    .flush_i      (flush_i),
    .rndr_done_i  (rndr_done_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int f_cnt    = 0;   // start words seen by the monitor
  int n_done   = 0;   // start words already consumed by the bench
  logic [15:0] words[$];
  logic [15:0] exp_q[$];

  // Capture every valid command word at the falling edge.
  always @(negedge clk) begin
    if (cmd_valid_o) begin
      words.push_back(cmd_o);
      if (cmd_o[15:12] == 4'hF) f_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_desc(input logic [11:0] x0, input logic [11:0] y0,
                           input logic [11:0] x1, input logic [11:0] y1,
                           input logic [7:0] c);
    desc_x0_i = x0; desc_y0_i = y0; desc_x1_i = x1; desc_y1_i = y1;
    desc_color_i = c;
    desc_valid_i = 1'b1;
    step();
    desc_valid_i = 1'b0;
  endtask

  task automatic add_seq(input logic [11:0] x0, input logic [11:0] y0,
                         input logic [11:0] x1, input logic [11:0] y1,
                         input logic [7:0] c, input bit with_color);
    exp_q.push_back({4'h0, x0});
    exp_q.push_back({4'h1, y0});
    exp_q.push_back({4'h2, x1});
    exp_q.push_back({4'h3, y1});
    if (with_color) exp_q.push_back({8'h40, c});
    exp_q.push_back(16'hF000);
  endtask

  task automatic cmp_words(input string tag);
    check({tag, "_len"}, 32'(words.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < words.size())
        check($sformatf("%s_w%0d", tag, i), 32'(words[i]), 32'(exp_q[i]));
    end
    words.delete();
    exp_q.delete();
  endtask

  // Wait (bounded) for the next unconsumed start word.
  task automatic wait_start(input string tag);
    int t = 0;
    while (f_cnt <= n_done && t < 100) begin
      step();
      t++;
    end
    check({tag, "_start"}, 32'(f_cnt > n_done), 32'd1);
    n_done++;
  endtask

  task automatic drain_one(input string tag);
    wait_start(tag);
    rndr_done_i = 1'b1;
    step();
    rndr_done_i = 1'b0;
  endtask

  task automatic wait_word(input logic [3:0] op, input string tag);
    int t = 0;
    while (!(cmd_valid_o && cmd_o[15:12] == op) && t < 100) begin
      step();
      t++;
    end
    check({tag, "_seen"}, 32'(cmd_valid_o && cmd_o[15:12] == op), 32'd1);
  endtask

  initial begin
    reset_n_i = 1'b0;
    desc_valid_i = 1'b0;
    desc_x0_i = '0; desc_y0_i = '0; desc_x1_i = '0; desc_y1_i = '0;
    desc_color_i = '0;
    flush_i = 1'b0;
    rndr_done_i = 1'b0;

    // Reset values.
    #2;
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_cmd",   32'(cmd_o),       32'h0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_ready", 32'(desc_ready_o), 32'd1);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    repeat (2) step();
    reset_n_i = 1'b1;
    step();

    // Single line, exact cycle timing.
    push_desc(12'd10, 12'd20, 12'd100, 12'd50, 8'h3A);     // edge E
    check("t1_e0_count", 32'(fifo_count_o), 32'd1);
    check("t1_e0_busy",  32'(busy_o),       32'd1);
    check("t1_e0_valid", 32'(cmd_valid_o),  32'd0);
    step();                                                 // E+1 pop
    check("t1_e1_count", 32'(fifo_count_o), 32'd0);
    check("t1_e1_valid", 32'(cmd_valid_o),  32'd0);
    add_seq(12'd10, 12'd20, 12'd100, 12'd50, 8'h3A, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();                                               // E+2 .. E+7
      check($sformatf("t1_v%0d", i), 32'(cmd_valid_o), 32'd1);
      check($sformatf("t1_w%0d", i), 32'(cmd_o), 32'(exp_q[i]));
    end
    exp_q.delete();
    step();
    check("t1_wait_valid", 32'(cmd_valid_o), 32'd0);
    check("t1_wait_busy",  32'(busy_o),      32'd1);
    check("t1_hold_cmd",   32'(cmd_o),       32'hF000);
    step();
    check("t1_wait2_valid", 32'(cmd_valid_o), 32'd0);
    rndr_done_i = 1'b1;
    step();
    rndr_done_i = 1'b0;
    check("t1_idle_busy", 32'(busy_o), 32'd0);
    n_done = 1;
    words.delete();

    // Colour reuse: same colour drops the 0x4 word, a new one brings it back.
    push_desc(12'd1, 12'd2, 12'd3, 12'd4, 8'h3A);
    drain_one("t2a");
    add_seq(12'd1, 12'd2, 12'd3, 12'd4, 8'h3A, 1'b0);
    cmp_words("t2a");
    push_desc(12'd5, 12'd6, 12'd7, 12'd8, 8'h05);
    drain_one("t2b");
    add_seq(12'd5, 12'd6, 12'd7, 12'd8, 8'h05, 1'b1);
    cmp_words("t2b");

    // Full FIFO while waiting, rejected fifth offer, order across wrap.
    push_desc(12'd11, 12'd12, 12'd13, 12'd14, 8'h05);
    wait_start("t3d0");
    push_desc(12'd21, 12'd22, 12'd23, 12'd24, 8'h11);
    push_desc(12'd31, 12'd32, 12'd33, 12'd34, 8'h22);
    push_desc(12'd41, 12'd42, 12'd43, 12'd44, 8'h33);
    push_desc(12'd51, 12'd52, 12'd53, 12'd54, 8'h44);
    check("t3_full_count", 32'(fifo_count_o), 32'd4);
    check("t3_full_ready", 32'(desc_ready_o), 32'd0);
    push_desc(12'd99, 12'd99, 12'd99, 12'd99, 8'h99);
    check("t3_fifth_count", 32'(fifo_count_o), 32'd4);
    rndr_done_i = 1'b1;
    step();
    rndr_done_i = 1'b0;
    check("t3_idle_count", 32'(fifo_count_o), 32'd4);
    step();
    check("t3_pop_count", 32'(fifo_count_o), 32'd3);
    check("t3_pop_ready", 32'(desc_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) drain_one($sformatf("t3d%0d", i + 1));
    add_seq(12'd11, 12'd12, 12'd13, 12'd14, 8'h05, 1'b0);
    add_seq(12'd21, 12'd22, 12'd23, 12'd24, 8'h11, 1'b1);
    add_seq(12'd31, 12'd32, 12'd33, 12'd34, 8'h22, 1'b1);
    add_seq(12'd41, 12'd42, 12'd43, 12'd44, 8'h33, 1'b1);
    add_seq(12'd51, 12'd52, 12'd53, 12'd54, 8'h44, 1'b1);
    cmp_words("t3");

    // Flush during the third word with two descriptors queued.
    push_desc(12'd61, 12'd62, 12'd63, 12'd64, 8'h44);
    push_desc(12'd71, 12'd72, 12'd73, 12'd74, 8'h44);
    push_desc(12'd81, 12'd82, 12'd83, 12'd84, 8'h44);
    wait_word(4'h2, "t4_third");
    check("t4_pre_count", 32'(fifo_count_o), 32'd2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("t4_valid", 32'(cmd_valid_o),  32'd0);
    check("t4_count", 32'(fifo_count_o), 32'd0);
    check("t4_busy",  32'(busy_o),       32'd0);
    words.delete();
    repeat (4) step();
    check("t4_no_words", 32'(words.size()), 32'd0);
    check("t4_no_start", 32'(f_cnt), 32'(n_done));
    // Colour matches the pre-flush cache but must still be sent.
    push_desc(12'd91, 12'd92, 12'd93, 12'd94, 8'h44);
    drain_one("t4f");
    add_seq(12'd91, 12'd92, 12'd93, 12'd94, 8'h44, 1'b1);
    cmp_words("t4f");

    // Asynchronous reset while waiting with three queued.
    push_desc(12'd1, 12'd1, 12'd2, 12'd2, 8'h5C);
    wait_start("t5g0");
    push_desc(12'd3, 12'd3, 12'd4, 12'd4, 8'h5C);
    push_desc(12'd5, 12'd5, 12'd6, 12'd6, 8'h5C);
    push_desc(12'd7, 12'd7, 12'd8, 12'd8, 8'h5C);
    check("t5_pre_count", 32'(fifo_count_o), 32'd3);
    #2 reset_n_i = 1'b0;
    #1;
    check("t5_rst_valid", 32'(cmd_valid_o),  32'd0);
    check("t5_rst_cmd",   32'(cmd_o),        32'h0);
    check("t5_rst_busy",  32'(busy_o),       32'd0);
    check("t5_rst_ready", 32'(desc_ready_o), 32'd1);
    check("t5_rst_count", 32'(fifo_count_o), 32'd0);
    repeat (2) step();
    reset_n_i = 1'b1;
    rndr_done_i = 1'b1;
    step();
    rndr_done_i = 1'b0;
    check("t5_stray_busy",  32'(busy_o),      32'd0);
    check("t5_stray_valid", 32'(cmd_valid_o), 32'd0);
    step();
    words.delete();
    // First push after reset: latency and colour word despite old cache.
    push_desc(12'd9, 12'd9, 12'd10, 12'd10, 8'h5C);        // edge E
    check("t5_e0_valid", 32'(cmd_valid_o), 32'd0);
    step();
    check("t5_e1_valid", 32'(cmd_valid_o), 32'd0);
    step();
    check("t5_e2_valid", 32'(cmd_valid_o), 32'd1);
    check("t5_e2_cmd",   32'(cmd_o),       32'h0009);
    drain_one("t5h");
    add_seq(12'd9, 12'd9, 12'd10, 12'd10, 8'h5C, 1'b1);
    cmp_words("t5h");

    // Done held through words 1..5, including the start-word edge.
    push_desc(12'hFFB, 12'd7, 12'd8, 12'd9, 8'h99);
    wait_word(4'h0, "t6_first");
    rndr_done_i = 1'b1;
    repeat (5) step();
    rndr_done_i = 1'b0;
    repeat (3) step();
    check("t6_wait_busy",  32'(busy_o),      32'd1);
    check("t6_wait_valid", 32'(cmd_valid_o), 32'd0);
    check("t6_one_start",  32'(f_cnt),       32'(n_done + 1));
    drain_one("t6");
    check("t6_idle_busy", 32'(busy_o), 32'd0);
    add_seq(12'hFFB, 12'd7, 12'd8, 12'd9, 8'h99, 1'b1);
    cmp_words("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prim_cmd_issuer.md
PRIM_CMD_ISSUER -- requirements
Module: prim_cmd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, line-descriptor FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports: clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have ports: reset_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: desc_valid_i  in  1  host offers a line descriptor.
REQ-005 SHALL have ports: desc_ready_o  out  1  FIFO can accept a descriptor.
REQ-006 SHALL have ports: desc_x0_i, desc_y0_i, desc_x1_i, desc_y1_i  in  12 each  line endpoints, signed.
REQ-007 SHALL have ports: desc_color_i  in  8  line color.
REQ-008 SHALL have ports: flush_i  in  1  discard queued work, abort the current line.
REQ-009 SHALL have ports: rndr_done_i  in  1  renderer line-complete pulse.
REQ-010 SHALL have ports: cmd_o  out  16  renderer command word, {opcode[3:0], payload[11:0]}.
REQ-011 SHALL have ports: cmd_valid_o  out  1  cmd_o valid this cycle (one word per high cycle).
REQ-012 SHALL have ports: busy_o  out  1  state != IDLE or FIFO non-empty.
REQ-013 SHALL have ports: fifo_count_o  out  $clog2(FIFO_DEPTH)+1  queued descriptors.

Function
REQ-014 SHALL accept a descriptor on a posedge with desc_valid_i && desc_ready_o; desc_ready_o = (count < FIFO_DEPTH), combinational from count only.
REQ-015 SHALL keep count unchanged on simultaneous push and pop, including when full.
REQ-016 SHALL use states IDLE, SEND, WAIT.
REQ-017 IDLE: if count > 0, pop the head into a descriptor register, set word index 0, go to SEND on the same edge.
REQ-018 SEND: emit one registered word per cycle, no gaps, in order: 0x0|x0, 0x1|y0, 0x2|x1, 0x3|y1, 0x4|{4'h0,color}, 0xF|12'h000.
REQ-019 SHALL skip the 0x4 color word when the color cache is valid and equal to the descriptor color; the sequence is then 5 words.
REQ-020 SHALL load the color cache and set it valid whenever a 0x4 word is emitted.
REQ-021 SHALL enter WAIT on the edge that emits the 0xF word.
REQ-022 SHALL treat the 0xF word as the start command; exactly one 0xF word per descriptor.
REQ-023 Latency: the first word has cmd_valid_o high in the cycle after the pop edge; with an empty FIFO and IDLE, a descriptor pushed at edge E is popped at E+1 and its first word is valid after E+2.
REQ-024 WAIT: rndr_done_i high returns the block to IDLE on that edge; the next pop occurs no earlier than the following edge.
REQ-025 SHALL ignore rndr_done_i in IDLE and SEND, including a done on the same edge the 0xF word is registered.
REQ-026 SHALL drive cmd_valid_o low in IDLE and WAIT; cmd_o holds its last value when invalid.
REQ-027 flush_i SHALL have priority over push, pop and rndr_done_i. On the next edge it SHALL:
  - empty the FIFO (count = 0);
  - force IDLE with cmd_valid_o low;
  - invalidate the color cache.
A push in the flush cycle is dropped.
REQ-028 SHALL NOT emit a partial sequence after flush; a flushed SEND sequence is abandoned, with no 0xF word.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; descriptors are emitted in push order.

Reset
REQ-030 reset_n_i low SHALL immediately, without waiting for clk, force the following; FIFO storage contents are don't-care:
  - state IDLE, count 0, both pointers 0;
  - color cache invalid;
  - cmd_valid_o 0, cmd_o 16'h0000;
  - busy_o 0, desc_ready_o 1.
REQ-031 After deassertion, the first push SHALL follow REQ-023, and its color word SHALL be emitted.

Verification
REQ-032 Single line: push (10,20,100,50,color 0x3A) at E -> words 0x000A,0x1014,0x2064,0x3032,0x403A,0xF000 valid after E+2..E+7; WAIT; rndr_done_i -> IDLE, busy_o 0.
REQ-033 Color reuse: two descriptors, both color 0x3A, done pulsed between them -> the second sequence has 5 words with no 0x4 word; a third descriptor with color 0x05 includes 0x4005.
REQ-034 Full FIFO: in WAIT, push 4 descriptors -> desc_ready_o 0, fifo_count_o 4; a fifth offer is not accepted. Then rndr_done_i -> pop, count 3, ready 1; all emitted in push order after wrap.
REQ-035 Flush mid-SEND: flush_i during the third word, with 2 queued -> cmd_valid_o 0 next cycle, count 0, no 0xF word. The next descriptor emits its color word even if the color matches.
REQ-036 Async reset in WAIT with 3 queued: reset_n_i low between edges -> outputs at reset values before the next posedge; a stray rndr_done_i after release is ignored.
REQ-037 Done in SEND: rndr_done_i pulsed during words 1..5 -> no state change; the block stays in WAIT until a later done.
